// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states,
// opcodes, ALUControl codes, datapath mux selects and the branch-taken helper.
// Pure declarations; no latency or backpressure of its own.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_LUI, S_AUIPC, S_ERROR
    } state_e;

    // Selects which decode the ALU decoder applies in the current state.
    typedef enum logic [1:0] {
        ALUOP_ADD, ALUOP_RTYPE, ALUOP_ITYPE, ALUOP_BRANCH
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // beq/bge/bgeu take on ZERO (equal, or slt/sltu result 0);
    // bne/blt/bltu take on ~ZERO.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic on_zero;
        on_zero = (funct3 == 3'b000) || (funct3 == 3'b101) || (funct3 == 3'b111);
        return on_zero ? zero : ~zero;
    endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the state's ALU mode plus funct3/funct7b5 to ALUControl.
// Latency: purely combinational. Backpressure: none.
// Ports: alu_op (mode from FSM), funct3, funct7b5 in; alu_control out.
module aludec
    import mc_controller_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    3'b000:  alu_control = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            ALUOP_BRANCH: begin
                // funct3[2:1]: 00 eq/ne, 10 signed compare, 11 unsigned compare
                case (funct3[2:1])
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_SUB;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I Moore controller driving PC/IR/memory/regfile enables and datapath muxes.
// Latency: load 5, store/ALU/AUIPC/JAL 4, branch/LUI 3, JALR 5 cycles. No backpressure.
// Ports: clk, reset (async high); Op/funct3/funct7b5/ZERO in; enables, mux selects, ALUControl, Illegal out.
// Build option ILLEGAL_TRAP_EN: undefined opcodes and branch funct3 010/011 lock into
// ERROR with Illegal=1 until reset; otherwise they retire as no-ops and Illegal stays 0.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       ZERO,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic       Illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_NEXT = S_ERROR;
`else
    localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif

    state_e  state_q, state_d;
    logic    rst_hold_q, rst_hold_d;
    alu_op_e alu_op;
    logic    pc_write_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;
    logic    en_block;

    // rst_hold_q stays set until the first clk edge after reset drops, so the
    // FETCH enables only appear from that edge on and FETCH gets a full cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= rst_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_hold_d  = 1'b0;
        pc_write_c  = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ImmSrc      = IMM_I;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_write_c = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (Op == OP_JAL) ? IMM_J : IMM_B;
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? ILLEGAL_NEXT : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (Op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_READDATA;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_RTYPE;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ITYPE;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_BRANCH;
                pc_write_c = branch_taken(funct3, ZERO);
                state_d    = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JAL;
            end
            S_JAL: begin
                // Writes PC from the ALUOut target, computes OldPC+4 as link.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                ImmSrc      = IMM_U;
                ResultSrc   = RES_IMMEXT;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_ERROR: begin
                illegal_c = 1'b1;
                state_d   = S_ERROR;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst_hold_q) begin
            state_d = S_FETCH;
        end
    end

    aludec u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Enables are forced low during reset and the cycle before FETCH starts.
    assign en_block = reset | rst_hold_q;
    assign PCWrite  = pc_write_c  & ~en_block;
    assign MemWrite = mem_write_c & ~en_block;
    assign IRWrite  = ir_write_c  & ~en_block;
    assign RegWrite = reg_write_c & ~en_block;
    assign Illegal  = illegal_c   & ~en_block;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters; all widths fixed for RV32I.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Op  in  7  instruction opcode.
REQ-005 funct3  in  3  instruction funct3.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 ZERO  in  1  ALU zero flag, sampled in BRANCH.
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address: 0=PC, 1=Result.
REQ-010 MemWrite  out  1  data memory write enable.
REQ-011 IRWrite  out  1  instruction/OldPC register enable.
REQ-012 ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult, 11=ImmExt.
REQ-013 ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1.
REQ-014 ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4.
REQ-015 ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
REQ-016 ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
REQ-017 RegWrite  out  1  register file write enable.
REQ-018 Illegal  out  1  illegal-instruction flag.

Function
REQ-019 SHALL be a Moore FSM; all outputs decoded from state, plus funct3/funct7b5/Op/ZERO where stated; unlisted outputs 0, ALUControl defaults to add.
REQ-020 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 -> DECODE.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=J if Op=1101111 else B; next by Op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, other per REQ-032.
REQ-022 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=I for load, S for store -> MEMREAD (load) or MEMWRITE (store).
REQ-023 MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB; MEMWB: ResultSrc=01, RegWrite=1 -> FETCH; MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH.
REQ-024 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I; both -> ALUWB; ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-025 ALU decode (EXECUTER/EXECUTEI) by funct3: 000 add (sub only in EXECUTER with funct7b5=1), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7b5, 110 or, 111 and.
REQ-026 BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00; ALUControl sub for funct3 00x, slt for 10x, sltu for 11x; PCWrite = taken; taken = ZERO for beq/bge/bgeu, ~ZERO for bne/blt/bltu; -> FETCH.
REQ-027 JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add -> JAL.
REQ-028 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-029 LUI: ImmSrc=U, ResultSrc=11, RegWrite=1 -> FETCH; AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=U, add -> ALUWB.
REQ-030 Latency: load 5, store 4, R/I-ALU 4, branch 3, LUI 3, AUIPC 4, JAL 4, JALR 5 cycles.

Reset
REQ-031 reset SHALL force state FETCH asynchronously and hold PCWrite, IRWrite, MemWrite, RegWrite, Illegal at 0 while asserted, including mid-instruction; FETCH outputs begin on the first clk edge after release.

Configuration
REQ-032 With ILLEGAL_TRAP_EN defined, undefined Op or branch funct3 010/011 SHALL go to ERROR (all enables 0, Illegal=1), held until reset; without it, such instructions return to FETCH as no-ops and Illegal is tied 0.

Structure
REQ-033 A shared package SHALL hold the state enum, opcode constants, and ALUControl and mux-select encodings.
REQ-034 ALU decode (REQ-025/026 ALUControl) SHALL be a combinational sub-module aludec.

Verification
REQ-035 Reset asserted in MEMREAD -> state FETCH immediately, all enables 0; first edge after release -> IRWrite=1, PCWrite=1.
REQ-036 Op=0000011 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5.
REQ-037 Op=0110011, funct3=000, funct7b5=1 -> ALUControl=0001 in EXECUTER, RegWrite=1 in ALUWB; funct3=101, funct7b5=1 -> 1001.
REQ-038 Op=1100011, funct3=001: ZERO=0 -> PCWrite=1, ZERO=1 -> PCWrite=0; funct3=110 -> ALUControl=0110.
REQ-039 Op=1100111 -> DECODE, JALR, JAL, ALUWB, FETCH; PCWrite=1 in JAL only.
REQ-040 Op=0000000 -> with ILLEGAL_TRAP_EN: ERROR, Illegal=1 held 10 cycles; without: FETCH next cycle, Illegal=0.
